// File: rtl/issue_pkg.sv
// Shared definitions for the issue stage: default widths, state encoding and
// the hardwired-zero register index.
package issue_pkg;

    localparam int unsigned DEF_OP_W = 6;
    localparam int unsigned DEF_XLEN = 32;

    // Kept as plain localparams so older code can compare against them directly
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/issue_hazard_chk.sv
// Source-operand hazard check: an instruction is blocked while any source it
// actually reads is still marked busy in the scoreboard.
module issue_hazard_chk (
    input  logic use_rs1,
    input  logic use_rs2,
    input  logic rs1_busy,
    input  logic rs2_busy,
    output logic blocked
);

    // Unused sources never block, whatever the scoreboard says about them
    always_comb begin
        blocked = (use_rs1 & rs1_busy) | (use_rs2 & rs2_busy);
    end

endmodule

// File: rtl/issue_stage.sv
// Single-entry issue stage between decode and execute.
// Optional macro ISSUE_STALL_CNT_EN adds a saturating busy-stall counter on
// perf_stall_cnt; without it the port is tied to zero.
module issue_stage
    import issue_pkg::*;
#(
    parameter int unsigned OP_W = DEF_OP_W,
    parameter int unsigned XLEN = DEF_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            dec_valid,
    output logic            dec_ready,
    input  logic [4:0]      dec_rs1,
    input  logic [4:0]      dec_rs2,
    input  logic [4:0]      dec_rd,
    input  logic            dec_use_rs1,
    input  logic            dec_use_rs2,
    input  logic [OP_W-1:0] dec_op,
    input  logic [XLEN-1:0] dec_imm,
    input  logic [XLEN-1:0] dec_pc,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic            rf_rs1_busy,
    input  logic            rf_rs2_busy,
    output logic [4:0]      rf_rd_exu,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [OP_W-1:0] ex_op,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd,
    output logic [31:0]     perf_stall_cnt
);

    logic [1:0]      state_q, state_d;
    logic [4:0]      h_rs1_q, h_rs2_q, h_rd_q;
    logic            h_use_rs1_q, h_use_rs2_q;
    logic [OP_W-1:0] h_op_q;
    logic [XLEN-1:0] h_imm_q, h_pc_q;

    logic blocked;
    logic accept;
    logic issue;
    logic in_hold;

    issue_hazard_chk u_hazard (
        .use_rs1  (h_use_rs1_q),
        .use_rs2  (h_use_rs2_q),
        .rs1_busy (rf_rs1_busy),
        .rs2_busy (rf_rs2_busy),
        .blocked  (blocked)
    );

    // Handshakes, register-file indices and the one-cycle busy-mark pulse
    always_comb begin
        in_hold   = (state_q == ST_HOLD);
        dec_ready = ((state_q == ST_EMPTY) && !flush) || ((state_q == ST_OUT) && ex_ready);
        accept    = dec_valid && dec_ready;
        // Flush beats issue so a cancelled instruction never marks its rd busy
        issue     = in_hold && !blocked && !flush;
        rf_rs1    = (in_hold && h_use_rs1_q) ? h_rs1_q : REG_ZERO;
        rf_rs2    = (in_hold && h_use_rs2_q) ? h_rs2_q : REG_ZERO;
        rf_rd_exu = issue ? h_rd_q : REG_ZERO;
        ex_valid  = (state_q == ST_OUT);
    end

    // Next-state logic; flush has no effect in OUT since rd is already busy
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_HOLD;
            ST_HOLD: begin
                if (flush)      state_d = ST_EMPTY;
                else if (issue) state_d = ST_OUT;
            end
            ST_OUT: if (ex_ready) state_d = accept ? ST_HOLD : ST_EMPTY;
            default: state_d = ST_EMPTY;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Hold register captures the decoded instruction on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_rs1_q     <= REG_ZERO;
            h_rs2_q     <= REG_ZERO;
            h_rd_q      <= REG_ZERO;
            h_use_rs1_q <= 1'b0;
            h_use_rs2_q <= 1'b0;
            h_op_q      <= '0;
            h_imm_q     <= '0;
            h_pc_q      <= '0;
        end else if (accept) begin
            h_rs1_q     <= dec_rs1;
            h_rs2_q     <= dec_rs2;
            h_rd_q      <= dec_rd;
            h_use_rs1_q <= dec_use_rs1;
            h_use_rs2_q <= dec_use_rs2;
            h_op_q      <= dec_op;
            h_imm_q     <= dec_imm;
            h_pc_q      <= dec_pc;
        end
    end

    // Execute-side registers load operands on the issue cycle and then stay stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_op  <= '0;
            ex_a   <= '0;
            ex_b   <= '0;
            ex_imm <= '0;
            ex_pc  <= '0;
            ex_rd  <= REG_ZERO;
        end else if (issue) begin
            ex_op  <= h_op_q;
            ex_a   <= h_use_rs1_q ? rf_rs1_data : '0;
            ex_b   <= h_use_rs2_q ? rf_rs2_data : '0;
            ex_imm <= h_imm_q;
            ex_pc  <= h_pc_q;
            ex_rd  <= h_rd_q;
        end
    end

`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles spent waiting on busy sources
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else if (in_hold && blocked && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule
